// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// exec_pkg : shared state encoding and ALU/shifter opcodes for exec_unit
// Rev 1.0
// ============================================================================
package exec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/exec_alu.sv
`default_nettype none
// ============================================================================
// exec_alu : B-operand shift/immediate select, ALU and {Z,N,V} flags
// Rev 1.0
// ============================================================================
module exec_alu
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op,
  input  logic [1:0]       shift,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  logic [WIDTH-1:0] b_sh;
  logic             v;

  always_comb begin
    b_sh = b;
    case (shift)
      SH_LSL:  b_sh = {b[WIDTH-2:0], 1'b0};
      SH_LSR:  b_sh = {1'b0, b[WIDTH-1:1]};
      SH_ASR:  b_sh = {b[WIDTH-1], b[WIDTH-1:1]};
      default: b_sh = b;
    endcase
    if (use_imm) begin
      b_sh = imm;
    end
  end

  // Overflow: operands of like sign (after inverting B for SUB) giving a result of the other sign.
  always_comb begin
    result = '0;
    v      = 1'b0;
    case (op)
      ALU_ADD: begin
        result = a + b_sh;
        v      = (a[WIDTH-1] == b_sh[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = a - b_sh;
        v      = (a[WIDTH-1] != b_sh[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b_sh;
      default: result = ~b_sh;
    endcase
  end

  assign flags = {(result == '0), result[WIDTH-1], v};

endmodule
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// exec_unit : 4-cycle execute stage (IDLE->READ->EXEC->WB) around a regfile
// Rev 1.0
// ============================================================================
module exec_unit
  import exec_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int SIZE       = 8,
  localparam int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [1:0]            shift,
  input  logic [ADDR_WIDTH-1:0] rn,
  input  logic [ADDR_WIDTH-1:0] rm,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  use_imm,
  input  logic [WIDTH-1:0]      imm,
  input  logic                  wb_en,
  output logic [ADDR_WIDTH-1:0] readnum1,
  output logic [ADDR_WIDTH-1:0] readnum2,
  input  logic [WIDTH-1:0]      rf_data1,
  input  logic [WIDTH-1:0]      rf_data2,
  output logic [ADDR_WIDTH-1:0] writenum,
  output logic                  write,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            status
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      a_q, a_d, b_q, b_d, c_q, c_d, imm_q, imm_d;
  logic [2:0]            status_q, status_d;
  logic [1:0]            op_q, op_d, shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
  logic                  use_imm_q, use_imm_d, wb_en_q, wb_en_d;

  logic [WIDTH-1:0]      alu_result;
  logic [2:0]            alu_flags;

  exec_alu #(.WIDTH(WIDTH)) u_alu (
    .op      (op_q),
    .shift   (shift_q),
    .a       (a_q),
    .b       (b_q),
    .use_imm (use_imm_q),
    .imm     (imm_q),
    .result  (alu_result),
    .flags   (alu_flags)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    status_d  = status_q;
    op_d      = op_q;
    shift_d   = shift_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    rd_d      = rd_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    wb_en_d   = wb_en_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          shift_d   = shift;
          rn_d      = rn;
          rm_d      = rm;
          rd_d      = rd;
          use_imm_d = use_imm;
          imm_d     = imm;
          wb_en_d   = wb_en;
          state_d   = READ;
        end
      end
      READ: begin
        a_d     = rf_data1;
        b_d     = rf_data2;
        state_d = EXEC;
      end
      EXEC: begin
        c_d      = alu_result;
        status_d = alu_flags;
        state_d  = WB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      status_q  <= '0;
      op_q      <= '0;
      shift_q   <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      wb_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      status_q  <= status_d;
      op_q      <= op_d;
      shift_q   <= shift_d;
      rn_q      <= rn_d;
      rm_q      <= rm_d;
      rd_q      <= rd_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      wb_en_q   <= wb_en_d;
    end
  end

  // Gating with reset keeps a WB cycle interrupted by reset from touching the regfile.
  assign readnum1 = rn_q;
  assign readnum2 = rm_q;
  assign writenum = rd_q;
  assign wb_data  = c_q;
  assign status   = status_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == WB) & ~reset;
  assign write    = (state_q == WB) & wb_en_q & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
// tb_exec_unit : scoreboard bench for exec_unit with a behavioural regfile
// Rev 1.0
// ============================================================================
module tb_exec_unit;

  typedef struct {
    logic [2:0]  wn;
    logic [15:0] data;
    logic [2:0]  st;
    logic        wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0, shift = '0;
  logic [2:0]  rn = '0, rm = '0, rd = '0;
  logic        use_imm = 1'b0, wb_en = 1'b0;
  logic [15:0] imm = '0;
  logic [2:0]  readnum1, readnum2, writenum;
  logic [15:0] rf_data1, rf_data2, wb_data;
  logic        write, busy, done;
  logic [2:0]  status;

  logic [15:0] rf [8];
  exp_t        sb [$];
  int          done_cyc [$];
  int          cyc = 0;
  int          phase = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  exec_unit #(.WIDTH(16), .SIZE(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shift(shift),
    .rn(rn), .rm(rm), .rd(rd), .use_imm(use_imm), .imm(imm), .wb_en(wb_en),
    .readnum1(readnum1), .readnum2(readnum2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .writenum(writenum), .write(write), .wb_data(wb_data),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  assign rf_data1 = rf[readnum1];
  assign rf_data2 = rf[readnum2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result as {result[15:0], Z, N, V}, overflow judged by integer range.
  function automatic logic [18:0] ref_op(input logic [1:0] o, input logic [1:0] s,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic ui, input logic [15:0] im);
    logic [15:0] bb, r;
    logic        v;
    int          sa, sb_i, sum;
    case (s)
      2'b01:   bb = {b[14:0], 1'b0};
      2'b10:   bb = b >> 1;
      2'b11:   bb = {b[15], b[15:1]};
      default: bb = b;
    endcase
    if (ui) bb = im;
    sa   = int'($signed(a));
    sb_i = int'($signed(bb));
    v    = 1'b0;
    case (o)
      2'b00: begin sum = sa + sb_i; r = sum[15:0]; v = (sum > 32767) || (sum < -32768); end
      2'b01: begin sum = sa - sb_i; r = sum[15:0]; v = (sum > 32767) || (sum < -32768); end
      2'b10: r = a & bb;
      default: r = ~bb;
    endcase
    return {r, (r == 16'h0), r[15], v};
  endfunction

  // Behavioural regfile: captures at the clock edge that ends a write cycle.
  initial begin
    foreach (rf[i]) rf[i] = 16'h0;
    rf[1] = 16'd5;
    rf[2] = 16'd3;
    rf[4] = 16'h7FFF;
    rf[5] = 16'h8004;
    forever begin
      @(posedge clk);
      if (write) rf[writenum] <= wb_data;
    end
  end

  // Acceptance tracker: start is honoured only every 4th cycle while idle.
  initial begin
    exp_t        e;
    logic [18:0] r;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        phase = 0;
        sb.delete();
      end else if (phase == 0) begin
        if (start) begin
          r      = ref_op(op, shift, rf[rn], rf[rm], use_imm, imm);
          e.wn   = rd;
          e.data = r[18:3];
          e.st   = r[2:0];
          e.wr   = wb_en;
          sb.push_back(e);
          phase = 1;
        end
      end else begin
        phase = (phase + 1) % 4;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("writenum", writenum, e.wn);
          check("wb_data", wb_data, e.data);
          check("status", status, e.st);
          check("write", write, e.wr);
        end
      end
      if (write) check("write_only_with_done", done, 1);
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [1:0] s, input logic [2:0] n,
                        input logic [2:0] m, input logic [2:0] d, input logic ui,
                        input logic [15:0] im, input logic we);
    int k;
    op = o; shift = s; rn = n; rm = m; rd = d; use_imm = ui; imm = im; wb_en = we;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_in_read", busy, 1);
    k = 1;
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("done_latency", k, 3);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", write, 0);
    check("rst_status", status, 0);
    check("rst_readnum1", readnum1, 0);
    check("rst_readnum2", readnum2, 0);
    check("rst_writenum", writenum, 0);
    check("rst_wb_data", wb_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // R3 = R1 + R2
    run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0, 1'b1);
    @(posedge clk); #1;
    check("r3_after_add", rf[3], 16'd8);
    @(negedge clk);

    // CMP R1, R1: flags only
    run_op(2'b01, 2'b00, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check("r1_after_cmp", rf[1], 16'd5);

    // R4 = 0x7FFF + #1 overflows to 0x8000
    run_op(2'b00, 2'b00, 3'd4, 3'd0, 3'd4, 1'b1, 16'h0001, 1'b1);
    @(negedge clk);
    check("r4_after_imm_add", rf[4], 16'h8000);

    // R6 = ~(R5 ASR 1)
    run_op(2'b11, 2'b11, 3'd0, 3'd5, 3'd6, 1'b0, 16'h0, 1'b1);
    @(negedge clk);
    check("r6_after_mvn_asr", rf[6], 16'h3FFD);

    // R7 = R2 LSL 1 AND R1, then LSR on an odd value
    run_op(2'b10, 2'b01, 3'd1, 3'd2, 3'd7, 1'b0, 16'h0, 1'b1);
    @(negedge clk);
    run_op(2'b00, 2'b10, 3'd0, 3'd5, 3'd7, 1'b0, 16'h0, 1'b1);
    @(negedge clk);

    // start held high for 12 cycles with a fresh ADD every cycle
    done_cyc.delete();
    for (int i = 0; i < 12; i++) begin
      op = 2'b00; shift = 2'b00; rn = 3'd1; rm = 3'd0; rd = 3'd7;
      use_imm = 1'b1; imm = 16'(i * 16 + 1); wb_en = 1'b1;
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("b2b_spacing_1", done_cyc[1] - done_cyc[0], 4);
      check("b2b_spacing_2", done_cyc[2] - done_cyc[1], 4);
    end

    // A second start while busy must be dropped
    done_cyc.delete();
    op = 2'b00; shift = 2'b00; rn = 3'd1; rm = 3'd2; rd = 3'd7; use_imm = 1'b0; wb_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    op = 2'b01; rd = 3'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_start_dropped", done_cyc.size(), 1);
    check("r2_untouched", rf[2], 16'd3);

    // Reset during WB of R3 = R4 + R4 (0x8000 + 0x8000)
    op = 2'b00; shift = 2'b00; rn = 3'd4; rm = 3'd4; rd = 3'd3; use_imm = 1'b0; wb_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_wb_write", write, 0);
    check("rst_wb_done", done, 0);
    check("rst_wb_status_pre", status, 3'b101);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_wb_busy", busy, 0);
    check("rst_wb_status", status, 0);
    check("rst_wb_r3", rf[3], 16'd8);

    // Recovery op after the interrupted one
    run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd0, 1'b0, 16'h0, 1'b1);
    @(negedge clk);
    check("r0_after_recovery", rf[0], 16'd8);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
